// File: rtl/gost_block_cipher.sv
`default_nettype none
// ============================================================================
//  Module      : gost_block_cipher
//  Description : GOST 28147-89 / Magma 64-bit block cipher core, 256-bit key.
//                One block per start request, start/busy/ready handshake.
//                ROUNDS_PER_CYCLE (1, 2, 4, 8) unrolls rounds per clock.
//                Define GOST_CBC_EN to add CBC chaining (cbc_i, iv_i,
//                iv_load and a 64-bit chain register); undefined = ECB only.
//  Ports       : clock, reset (async, active-high)
//                start, enc_dec, data_i[63:0], key_i[255:0]  - request
//                cbc_i, iv_i[63:0], iv_load                  - GOST_CBC_EN only
//                data_o[63:0], busy_o, ready_o               - result/status
//  Revision    : 1.0 - initial release
// ============================================================================
module gost_block_cipher #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         enc_dec,
   input  logic [63:0]  data_i,
   input  logic [255:0] key_i,
`ifdef GOST_CBC_EN
   input  logic         cbc_i,
   input  logic [63:0]  iv_i,
   input  logic         iv_load,
`endif
   output logic [63:0]  data_o,
   output logic         busy_o,
   output logic         ready_o
);

   localparam int C_GROUPS = 32 / ROUNDS_PER_CYCLE;
   localparam int C_CNT_W  = $clog2(C_GROUPS);
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_GROUPS - 1);

   // Magma S-boxes pi7..pi0; entry x of a box sits at bits [4x+3:4x].
   localparam logic [7:0][63:0] C_SBOX = {
      64'h2BC96AF43850DE71, 64'h73AD0B4FC19652E8,
      64'h0E34187BAC296FD5, 64'hC24BE390D618A5F7,
      64'hB9E35A076F4D128C, 64'h069C471EDAF2853B,
      64'hF0DB74E1C5A93286, 64'h1F307D8E9B5A264C
   };

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [63:0]          r_blk;
   logic [255:0]         r_key;
   logic                 r_enc;
   logic [63:0]          w_blk_in;
   logic [63:0]          w_result;
   logic [63:0]          w_next;

   // S-box substitution followed by rotate-left by 11
   function automatic logic [31:0] f_g(input logic [31:0] x);
      logic [31:0] s;
      s = '0;
      for (int n = 0; n < 8; n++)
         s[4*n +: 4] = C_SBOX[n][{x[4*n +: 4], 2'b00} +: 4];
      return {s[20:0], s[31:21]};
   endfunction

   // Encrypt runs forward key order for rounds 0-23, decrypt only for 0-7;
   // every later round uses reversed order, i.e. index 7 - (r mod 8).
   function automatic logic [2:0] f_key_idx(input logic enc, input logic [4:0] rnd);
      logic late;
      late = enc ? (rnd >= 5'd24) : (rnd >= 5'd8);
      return late ? ~rnd[2:0] : rnd[2:0];
   endfunction

   // K[j] is the j-th 32-bit word counted from the most significant end
   function automatic logic [31:0] f_subkey(input logic [255:0] key, input logic [2:0] j);
      return key[{~j, 5'b00000} +: 32];
   endfunction

   for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
      logic [63:0] w_in;
      logic [63:0] w_out;
      logic [4:0]  w_rnd;
      logic [31:0] w_g;

      if (i == 0) begin : g_first
         assign w_in = r_blk;
      end else begin : g_chain
         assign w_in = g_round[i-1].w_out;
      end

      assign w_rnd = 5'(int'(r_cnt) * ROUNDS_PER_CYCLE + i);
      assign w_g   = f_g(w_in[31:0] + f_subkey(r_key, f_key_idx(r_enc, w_rnd)));
      // The final round leaves the halves unswapped
      assign w_out = (w_rnd == 5'd31) ? {w_in[63:32] ^ w_g, w_in[31:0]}
                                      : {w_in[31:0], w_in[63:32] ^ w_g};
   end

   assign w_next = g_round[ROUNDS_PER_CYCLE-1].w_out;

`ifdef GOST_CBC_EN
   logic        r_cbc;
   logic [63:0] r_chain;
   logic [63:0] r_din;
   logic [63:0] w_chain_now;

   // An IV loaded in the same cycle as start is the one used for that block
   assign w_chain_now = iv_load ? iv_i : r_chain;
   assign w_blk_in    = data_i ^ ((cbc_i & enc_dec) ? w_chain_now : 64'h0);
   assign w_result    = r_blk ^ ((r_cbc & ~r_enc) ? r_chain : 64'h0);
`else
   assign w_blk_in    = data_i;
   assign w_result    = r_blk;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_blk   <= '0;
         r_key   <= '0;
         r_enc   <= 1'b0;
         data_o  <= '0;
         busy_o  <= 1'b0;
         ready_o <= 1'b0;
`ifdef GOST_CBC_EN
         r_cbc   <= 1'b0;
         r_chain <= '0;
         r_din   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               ready_o <= 1'b0;
`ifdef GOST_CBC_EN
               if (iv_load)
                  r_chain <= iv_i;
`endif
               if (start) begin
                  r_key   <= key_i;
                  r_enc   <= enc_dec;
                  r_blk   <= w_blk_in;
                  r_cnt   <= '0;
                  busy_o  <= 1'b1;
                  r_state <= S_RUN;
`ifdef GOST_CBC_EN
                  r_cbc   <= cbc_i;
                  r_din   <= data_i;
`endif
               end
            end
            S_RUN: begin
               r_blk <= w_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == C_LAST) begin
                  busy_o  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               data_o  <= w_result;
               ready_o <= 1'b1;
               r_state <= S_IDLE;
`ifdef GOST_CBC_EN
               // Chain follows the ciphertext side in both directions
               if (r_cbc)
                  r_chain <= r_enc ? r_blk : r_din;
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/gost_block_cipher.md
# gost_block_cipher

Parametrised GOST 28147-89 / Magma (GOST R 34.12-2015) 64-bit block cipher core; successor to the single-configuration `criptografia_GOST` engine. Encrypts or decrypts one 64-bit block per request under a 256-bit key, using a start/busy/ready handshake. A parameter trades area for latency by unrolling 1–8 rounds per clock. Optional CBC chaining is compiled in by macro. Sits between the host register interface and the data path.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds evaluated per clock; legal values 1, 2, 4, 8.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `enc_dec`  in  1  1 = encrypt, 0 = decrypt; latched with `start`.
- `data_i`  in  64  input block; latched with `start`.
- `key_i`  in  256  key; latched with `start`.
- `data_o`  out  64  result; holds value until next accepted `start`.
- `busy_o`  out  1  high while rounds execute.
- `ready_o`  out  1  one-cycle pulse: `data_o` valid.
- `cbc_i`  in  1  (GOST_CBC_EN only) 1 = CBC, 0 = ECB; latched with `start`.
- `iv_i`  in  64  (GOST_CBC_EN only) initial vector.
- `iv_load`  in  1  (GOST_CBC_EN only) loads `iv_i` into chain register; honoured only in IDLE.

## Operation
- Subkeys: K[j] = `key_i`[255-32j -: 32], j = 0..7 (K[0] = most significant word).
- Block split: a1 = bits 63:32, a0 = bits 31:0.
- Round with key k: g = ROL11(S(a0 + k mod 2^32)); (a1, a0) <= (a0, a1 ^ g). S applies the Magma S-box set π0..π7, π0 to nibble 3:0.
- Encrypt schedule: rounds 0–23 use K[r mod 8], rounds 24–31 use K[7 - (r mod 8)]. Decrypt: rounds 0–7 use K[r], rounds 8–31 use K[7 - (r mod 8)].
- Round 31 has no swap: output = {a1 ^ g, a0}.
- FSM: IDLE → (start) RUN → (last round group) DONE → IDLE.
  - IDLE: `start`=1 latches inputs, clears round counter, enters RUN.
  - RUN: executes `ROUNDS_PER_CYCLE` rounds per clock; counter width clog2(32/ROUNDS_PER_CYCLE); counter wrap enters DONE.
  - DONE: drives `data_o`, pulses `ready_o`, returns to IDLE.
- `start` in RUN or DONE is ignored, with no queueing. `start` held high re-triggers on each IDLE cycle.
- Changes to `key_i`/`data_i` after the start cycle have no effect on the current block.

## Timing
- Reset values: `data_o`=0, `busy_o`=0, `ready_o`=0, FSM=IDLE, counter=0, chain register=0.
- `start` at edge T → `busy_o` high from T+1 for 32/ROUNDS_PER_CYCLE cycles → `ready_o` high and `data_o` updated one cycle after `busy_o` falls.
- Latency from start edge to `ready_o` = 32/ROUNDS_PER_CYCLE + 1 cycles (33, 17, 9, 5).
- Throughput: one block per latency+1 cycles; next `start` is accepted the cycle `ready_o` is high at earliest (FSM already IDLE there).
- Reset asserted mid-operation: all state clears immediately; the block is discarded and no `ready_o` is issued.

## Configuration
- `GOST_CBC_EN` defined: adds `cbc_i`, `iv_i`, `iv_load` and a 64-bit chain register.
  - CBC encrypt: cipher input = `data_i` ^ chain; chain <= ciphertext at DONE.
  - CBC decrypt: `data_o` = cipher output ^ chain; chain <= latched `data_i` at DONE.
  - ECB (`cbc_i`=0): chain is untouched.
  - `iv_load` and `start` in the same IDLE cycle: IV loads first and is used for that block.
- Undefined: ECB only; no extra ports or register.

## Test plan
- ROUNDS_PER_CYCLE=1, encrypt, key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data fedcba9876543210 → `data_o`=4ee901e5c2d8ca3d with `ready_o` 33 cycles after start; `busy_o` high for exactly 32 cycles.
- Same key, decrypt 4ee901e5c2d8ca3d → fedcba9876543210; repeat for ROUNDS_PER_CYCLE=2, 4, 8 with latencies 17, 9, 5.
- Pulse `start` again at busy+3 with different data → ignored, first result unchanged, single `ready_o` pulse.
- Assert `reset` at busy+10 → `busy_o`, `ready_o`, `data_o` zero next cycle; a new start then yields a correct result.
- GOST_CBC_EN: IV=0 with block fedcba9876543210 → 4ee901e5c2d8ca3d.
- GOST_CBC_EN: second block → E(P2 ^ C1) from the bench model; CBC decrypt of both blocks with the same IV restores the plaintexts.
